// File: rtl/cache_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_seq_pkg
// Description : Shared types and constants for the cache request sequencer.
//               The FSM state encoding, the fixed index/counter widths and
//               a saturating-increment helper live here. The request struct
//               is declared in the top level because its field widths follow
//               the top's TAG_WIDTH / DATA_WIDTH parameters.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_seq_pkg;

  localparam int INDEX_WIDTH = 6;
  localparam int CNT_WIDTH   = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RESP   = 3'd4
  } state_e;

  // Statistics counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == {CNT_WIDTH{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cache_req_fifo.sv
`default_nettype none
// ============================================================================
// Module      : cache_req_fifo
// Description : Show-ahead synchronous FIFO holding request entries.
//               push_i is ignored while full (even with a same-cycle pop),
//               pop_i is ignored while empty. rdata_o always shows the head.
// Ports       : clk, rst (async, active-high)
//               push_i / wdata_i  - write side
//               pop_i  / rdata_o  - read side (head entry)
//               full_o, empty_o   - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module cache_req_fifo #(
  parameter int  FIFO_DEPTH = 4,
  parameter type ENTRY_T    = logic
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push_i,
  input  ENTRY_T wdata_i,
  input  logic   pop_i,
  output ENTRY_T rdata_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = FIFO_DEPTH[AW:0];

  ENTRY_T          mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wptr_q;
  logic [AW-1:0]   rptr_q;
  logic [AW:0]     count_q;
  logic            w_push;
  logic            w_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q];

  // Depth is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (w_push) wptr_q <= wptr_q + 1'b1;
      if (w_pop)  rptr_q <= rptr_q + 1'b1;
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule
`default_nettype wire

// File: rtl/cache_req_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cache_req_sequencer
// Description : Front end for the 64-line direct-mapped cache. Queues
//               requests, drives each one to the cache as a two-cycle
//               read/write command, waits for cache_ready (or times out),
//               emits one response pulse and keeps read hit/miss counts.
// Ports       : clk, rst (async, active-high)
//               req_*   - request valid/ready interface (req_ready = !full)
//               cache_* / addr_* / write_data / read_data - cache side
//               rsp_*   - one-cycle response (rsp_valid qualifies the rest)
//               hit_count, miss_count - saturating read statistics
//               busy    - FSM active or requests queued
// Revision    : 1.0 - initial release
// ============================================================================
module cache_req_sequencer
  import cache_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [TAG_WIDTH-1:0]   req_tag,
  input  logic [INDEX_WIDTH-1:0] req_index,
  input  logic [DATA_WIDTH-1:0]  req_wdata,
  output logic                   cache_read,
  output logic                   cache_write,
  output logic [TAG_WIDTH-1:0]   addr_tag,
  output logic [INDEX_WIDTH-1:0] addr_index,
  output logic [DATA_WIDTH-1:0]  write_data,
  input  logic [DATA_WIDTH-1:0]  read_data,
  input  logic                   cache_hit,
  input  logic                   cache_ready,
  output logic                   rsp_valid,
  output logic                   rsp_write,
  output logic                   rsp_hit,
  output logic                   rsp_err,
  output logic [DATA_WIDTH-1:0]  rsp_data,
  output logic [CNT_WIDTH-1:0]   hit_count,
  output logic [CNT_WIDTH-1:0]   miss_count,
  output logic                   busy
);

  typedef struct packed {
    logic                   write;
    logic [TAG_WIDTH-1:0]   tag;
    logic [INDEX_WIDTH-1:0] index;
    logic [DATA_WIDTH-1:0]  wdata;
  } req_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_e                 state_q, state_d;
  req_t                   w_fifo_in, w_fifo_out, hold_q;
  logic                   w_full, w_empty, w_pop;
  logic [7:0]             timer_q;
  logic                   rsp_hit_q, rsp_err_q;
  logic [DATA_WIDTH-1:0]  rdata_q;
  logic [CNT_WIDTH-1:0]   hit_cnt_q, miss_cnt_q;

  assign w_fifo_in = '{write: req_write, tag: req_tag, index: req_index, wdata: req_wdata};

  cache_req_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .ENTRY_T    (req_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (req_valid),
    .wdata_i (w_fifo_in),
    .pop_i   (w_pop),
    .rdata_o (w_fifo_out),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  assign req_ready  = !w_full;
  assign addr_tag   = hold_q.tag;
  assign addr_index = hold_q.index;
  assign write_data = hold_q.wdata;
  assign rsp_write  = hold_q.write;
  assign rsp_hit    = rsp_hit_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_data   = rdata_q;
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
  assign busy       = (state_q != ST_IDLE) || !w_empty;

  // The command is asserted in ISSUE and ACCESS only, so it is already low
  // in WAIT when cache_ready arrives.
  always_comb begin
    state_d     = state_q;
    w_pop       = 1'b0;
    cache_read  = 1'b0;
    cache_write = 1'b0;
    rsp_valid   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop   = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cache_read  = !hold_q.write;
        cache_write = hold_q.write;
        state_d     = ST_ACCESS;
      end
      ST_ACCESS: begin
        cache_read  = !hold_q.write;
        cache_write = hold_q.write;
        state_d     = ST_WAIT;
      end
      ST_WAIT: begin
        if (cache_ready || (timer_q == TMO_LAST)) state_d = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      hold_q     <= '0;
      timer_q    <= '0;
      rsp_hit_q  <= 1'b0;
      rsp_err_q  <= 1'b0;
      rdata_q    <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (w_pop) begin
        hold_q    <= w_fifo_out;
        rsp_err_q <= 1'b0;
        rdata_q   <= '0;
      end
      // Hit is sampled before a write completes, i.e. the pre-write status.
      if (state_q == ST_ACCESS) begin
        rsp_hit_q <= cache_hit;
        timer_q   <= '0;
      end
      if (state_q == ST_WAIT) begin
        timer_q <= timer_q + 1'b1;
        if (cache_ready) begin
          if (!hold_q.write) rdata_q <= read_data;
        end else if (timer_q == TMO_LAST) begin
          rsp_err_q <= 1'b1;
        end
      end
      if ((state_q == ST_RESP) && !hold_q.write && !rsp_err_q) begin
        if (rsp_hit_q) hit_cnt_q  <= sat_inc(hit_cnt_q);
        else           miss_cnt_q <= sat_inc(miss_cnt_q);
      end
    end
  end

endmodule
`default_nettype wire
